// File: rtl/hams_pkg.sv
// Shared types and constants for the HAMS merge-sort datapath.
//   merge_state_t : state encoding of the 2-way merge controller.
//   HamsDataW     : default key width shared by the controller and its FIFOs.
package hams_pkg;

  localparam int unsigned HamsDataW = 8;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN_A,
    DRAIN_B,
    DONE
  } merge_state_t;

endpackage

// File: rtl/hams_merge_cmp.sv
// Head comparator for one 2-way merge step (purely combinational).
// Ports:
//   a_data, b_data : show-ahead heads of FIFO A and FIFO B.
//   sel_a          : 1 when A's head is emitted next (ties go to A for stability).
//   sel_data       : the selected head word.
module hams_merge_cmp #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          ASCENDING = 1'b1
) (
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              sel_a,
  output logic [DATA_W-1:0] sel_data
);

  always_comb begin
    if (ASCENDING) begin
      sel_a = (a_data <= b_data);
    end else begin
      sel_a = (a_data >= b_data);
    end
    sel_data = sel_a ? a_data : b_data;
  end

endmodule

// File: rtl/hams_merge_ctrl.sv
// Controller for one 2-way merge step: drains one sorted run of run_len words from
// each of FIFO A and FIFO B and pushes the merged 2*run_len-word run to the output FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset.
//   start, run_len      : begin a merge step (IDLE only), words per input run.
//   busy, done          : high outside IDLE, one-cycle completion pulse.
//   a_empty/a_data/a_pop: FIFO A show-ahead head and pop.
//   b_empty/b_data/b_pop: FIFO B show-ahead head and pop.
//   o_full/o_push/o_data: output FIFO handshake and data.
module hams_merge_ctrl
  import hams_pkg::*;
#(
  parameter int unsigned DATA_W    = HamsDataW,
  parameter int unsigned LEN_W     = 16,
  parameter bit          ASCENDING = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  run_len,
  output logic              busy,
  output logic              done,
  input  logic              a_empty,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_pop,
  input  logic              b_empty,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_pop,
  input  logic              o_full,
  output logic              o_push,
  output logic [DATA_W-1:0] o_data
);

  merge_state_t     state_q, state_d;
  logic [LEN_W-1:0] cnt_a_q, cnt_a_d;
  logic [LEN_W-1:0] cnt_b_q, cnt_b_d;
  logic             sel_a;
  logic [DATA_W-1:0] sel_data;

  hams_merge_cmp #(
    .DATA_W    (DATA_W),
    .ASCENDING (ASCENDING)
  ) u_cmp (
    .a_data   (a_data),
    .b_data   (b_data),
    .sel_a    (sel_a),
    .sel_data (sel_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    a_pop   = 1'b0;
    b_pop   = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    o_data  = a_data;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_a_d = run_len;
          cnt_b_d = run_len;
          state_d = (run_len == '0) ? DONE : MERGE;
        end
      end
      MERGE: begin
        o_data = sel_data;
        if (!a_empty && !b_empty && !o_full && cnt_a_q != '0 && cnt_b_q != '0) begin
          if (sel_a) begin
            a_pop   = 1'b1;
            cnt_a_d = cnt_a_q - LEN_W'(1);
            if (cnt_a_q == LEN_W'(1)) state_d = DRAIN_B;
          end else begin
            b_pop   = 1'b1;
            cnt_b_d = cnt_b_q - LEN_W'(1);
            if (cnt_b_q == LEN_W'(1)) state_d = DRAIN_A;
          end
        end
      end
      DRAIN_A: begin
        if (cnt_a_q == '0) begin
          state_d = DONE;
        end else if (!a_empty && !o_full) begin
          a_pop   = 1'b1;
          cnt_a_d = cnt_a_q - LEN_W'(1);
          if (cnt_a_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DRAIN_B: begin
        o_data = b_data;
        if (cnt_b_q == '0) begin
          state_d = DONE;
        end else if (!b_empty && !o_full) begin
          b_pop   = 1'b1;
          cnt_b_d = cnt_b_q - LEN_W'(1);
          if (cnt_b_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The state register still holds the pre-reset state during the reset cycle,
    // so handshakes and status are suppressed combinationally to keep FIFOs untouched.
    if (rst) begin
      a_pop = 1'b0;
      b_pop = 1'b0;
      done  = 1'b0;
      busy  = 1'b0;
    end
    o_push = a_pop | b_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

endmodule
